acc_issue: RTL

ACC_ISSUE -- requirements
Module: acc_issue

---
 rtl/acc_pkg.sv | 26 ++
 rtl/acc_wb_fifo.sv | 48 ++++
 rtl/acc_issue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accelerator issue slice: instruction word, register
// address type and a helper that turns an address into a scoreboard mask.
package acc_pkg;

    localparam int NUM_SRC  = 3;
    localparam int NUM_REGS = 32;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic [6:0] op;
        reg_addr_t  rd;
        reg_addr_t  rs1;
        reg_addr_t  rs2;
        reg_addr_t  rs3;
    } acc_instr_t;

    // x0 is hard-wired zero, so it never maps onto a scoreboard bit
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] mask;
        mask = '0;
        if (addr != '0) mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/acc_wb_fifo.sv
// Writeback FIFO for accelerator results; DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted only alongside a pop.
module acc_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count == (PW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/acc_issue.sv
// Accelerator issue/operand/writeback controller with a register scoreboard.
// Define ACC_ISSUE_FWD_EN to forward CPU writeback data into operand reads.
module acc_issue
    import acc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WB_DEPTH   = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  acc_instr_t                           ex_instr_i,
    input  logic                                 ex_valid_i,
    output logic                                 ex_stall_o,
    output acc_instr_t                           acc_instr_o,
    output logic                                 acc_instr_valid_o,
    input  logic                                 acc_ready_i,
    input  logic                                 acc_busy_i,
    input  reg_addr_t [NUM_SRC-1:0]              acc_raddr_i,
    output logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   acc_rdata_o,
    output logic                                 acc_rvalid_o,
    input  reg_addr_t                            acc_waddr_i,
    input  logic [DATA_WIDTH-1:0]                acc_wdata_i,
    input  logic                                 acc_wren_i,
    input  reg_addr_t                            cpu_wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                cpu_wb_data_i,
    input  logic                                 cpu_wb_valid_i,
    output logic [DATA_WIDTH-1:0]                fwd_data_o,
    output logic                                 fwd_valid_o,
    output reg_addr_t [NUM_SRC-1:0]              rf_raddr_o,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   rf_rdata_i,
    output reg_addr_t                            rf_waddr_o,
    output logic [DATA_WIDTH-1:0]                rf_wdata_o,
    output logic                                 rf_we_o,
    input  logic                                 rf_wgnt_i,
    output logic                                 wb_overflow_o
);

    localparam int ENT_W = $bits(reg_addr_t) + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, OPREAD, RESP} state_t;

    state_t                              state_q, state_d;
    logic                                load_instr, load_rdata;
    logic [NUM_REGS-1:0]                 sb_q, sb_set, sb_clr;
    logic [NUM_SRC-1:0]                  src_hazard, src_fwd;
    logic                                ops_ready;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  rdata_d;
    logic                                fifo_full, fifo_empty, fifo_pop;
    logic [ENT_W-1:0]                    fifo_head;
    reg_addr_t                           head_addr;
    logic [DATA_WIDTH-1:0]               head_data;

    acc_wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (acc_wren_i),
        .din_i   ({acc_waddr_i, acc_wdata_i}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign {head_addr, head_data} = fifo_head;

    // No commit can leave the FIFO while reset is being applied
    assign rf_we_o    = ~fifo_empty & ~rst_i;
    assign rf_waddr_o = fifo_empty ? '0 : head_addr;
    assign rf_wdata_o = fifo_empty ? '0 : head_data;
    assign fifo_pop   = rf_we_o & rf_wgnt_i;

    assign rf_raddr_o        = acc_raddr_i;
    assign acc_instr_valid_o = (state_q == ISSUE);
    assign acc_rvalid_o      = (state_q == RESP);
    assign ex_stall_o        = ex_valid_i & (state_q != RESP);

    always_comb begin
        src_hazard = '0;
        src_fwd    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_hazard[k] = (acc_raddr_i[k] != '0) & sb_q[acc_raddr_i[k]];
            src_fwd[k]    = cpu_wb_valid_i & (cpu_wb_addr_i != '0) &
                            (acc_raddr_i[k] == cpu_wb_addr_i);
        end
    end

`ifdef ACC_ISSUE_FWD_EN
    assign ops_ready   = ~|src_hazard;
    assign fwd_valid_o = (state_q == OPREAD) & (|src_fwd);
    assign fwd_data_o  = fwd_valid_o ? cpu_wb_data_i : '0;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++)
            rdata_d[k] = src_fwd[k] ? cpu_wb_data_i : rf_rdata_i[k];
    end
`else
    // Without forwarding, a source being written by the CPU this cycle must wait
    logic fwd_data_unused;
    assign fwd_data_unused = ^cpu_wb_data_i;
    assign ops_ready       = ~|(src_hazard | src_fwd);
    assign fwd_valid_o     = 1'b0;
    assign fwd_data_o      = '0;
    assign rdata_d         = rf_rdata_i;
`endif

    assign sb_set = (acc_instr_valid_o & acc_ready_i) ? reg_onehot(acc_instr_o.rd) : '0;
    assign sb_clr = fifo_pop ? reg_onehot(head_addr) : '0;

    always_comb begin
        state_d    = state_q;
        load_instr = 1'b0;
        load_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid_i && !acc_busy_i && !fifo_full) begin
                    state_d    = ISSUE;
                    load_instr = 1'b1;
                end
            end
            ISSUE:   if (acc_ready_i) state_d = OPREAD;
            OPREAD: begin
                if (ops_ready) begin
                    state_d    = RESP;
                    load_rdata = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            sb_q          <= '0;
            wb_overflow_o <= 1'b0;
            acc_instr_o   <= '0;
            acc_rdata_o   <= '0;
        end else begin
            state_q       <= state_d;
            // A set in the same cycle as a clear of that bit wins
            sb_q          <= (sb_q & ~sb_clr) | sb_set;
            wb_overflow_o <= wb_overflow_o | (acc_wren_i & fifo_full & ~fifo_pop);
            if (load_instr) acc_instr_o <= ex_instr_i;
            if (load_rdata) acc_rdata_o <= rdata_d;
        end
    end

endmodule
